exec_unit_pipelined: RTL

Parametrised successor to the combinational execute stage: an EX stage with a registered EX/MEM output slot, a valid/ready handshake on both sides, and internal flag and stack-pointer registers. It adds a multi-cycle iterative multiply alongside the single-cycle ALU ops. It sits between the ID/EX buffer and the memory stage and absorbs downstream back-pressure.

---
 rtl/exec_unit_pipelined.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/exec_unit_pipelined.sv
// EX stage with a registered EX/MEM slot, valid/ready on both sides, flag/SP registers and an iterative MUL.
// Build option EXEC_DIV_EN adds a restoring unsigned divider for op 9; otherwise op 9 is a single-cycle PASS.
module exec_unit_pipelined #(
    parameter int                 DATA_W   = 16,
    parameter int                 ADDR_W   = 32,
    parameter int                 CTRL_W   = 12,
    parameter logic [ADDR_W-1:0]  SP_RESET = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] opa,
    input  logic [DATA_W-1:0] opb,
    input  logic [1:0]        fd,
    input  logic              sp_en,
    input  logic              sp_pop,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic              flags_load,
    input  logic [2:0]        flags_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [2:0]        flags,
    output logic [ADDR_W-1:0] sp,
    output logic              busy
);

    // state | meaning
    // IDLE  | accepts instructions when the slot is free or draining
    // ITER  | multi-cycle op iterating, one step per cycle for DATA_W cycles
    // DONE  | result ready, waiting for a free slot
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_SHL = 4'd4;
    localparam logic [3:0] OP_SHR = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [1:0]          state_q, state_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
    logic [CTRL_W-1:0]   out_ctrl_q, out_ctrl_d;
    logic [2:0]          flags_q, flags_d;
    logic [ADDR_W-1:0]   sp_q, sp_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   mc_b_q, mc_b_d;
    logic [1:0]          mc_fd_q, mc_fd_d;
    logic [ADDR_W-1:0]   mc_addr_q, mc_addr_d;
    logic [CTRL_W-1:0]   mc_ctrl_q, mc_ctrl_d;

    logic                fire, slot_free, is_mc, mc_cf;
    logic [DATA_W:0]     add_w, sub_w, shl_w, mul_sum;
    logic [DATA_W-1:0]   alu_res, sc_res;
    logic                alu_cf, alu_cf_vld;
    logic [ADDR_W-1:0]   sp_inc, sp_dec, sc_addr;
    logic [2*DATA_W-1:0] mul_acc, acc_step;

    assign slot_free = !out_valid_q || out_ready;
    assign in_ready  = (state_q == S_IDLE) && slot_free;
    assign fire      = in_valid && in_ready;

    assign add_w  = {1'b0, opa} + {1'b0, opb};
    assign sub_w  = {1'b0, opa} - {1'b0, opb};
    // Bit DATA_W of the widened shift is the last bit pushed out of opa.
    assign shl_w  = {1'b0, opa} << opb;
    assign sp_inc = sp_q + ADDR_W'(1);
    assign sp_dec = sp_q - ADDR_W'(1);

    always_comb begin
        alu_res    = opa;
        alu_cf     = 1'b0;
        alu_cf_vld = 1'b0;
        case (alu_op)
            OP_ADD: begin alu_res = add_w[DATA_W-1:0]; alu_cf = add_w[DATA_W]; alu_cf_vld = 1'b1; end
            OP_SUB: begin alu_res = sub_w[DATA_W-1:0]; alu_cf = sub_w[DATA_W]; alu_cf_vld = 1'b1; end
            OP_AND: alu_res = opa & opb;
            OP_OR:  alu_res = opa | opb;
            OP_SHL: begin alu_res = shl_w[DATA_W-1:0]; alu_cf = shl_w[DATA_W]; alu_cf_vld = 1'b1; end
            OP_SHR: alu_res = opa >> opb;
            OP_NOT: alu_res = ~opa;
            default: alu_res = opa;
        endcase
    end

    assign sc_res  = sp_en ? opa : alu_res;
    assign sc_addr = sp_en ? (sp_pop ? sp_inc : sp_q)
                           : (ctrl_in[0] ? ADDR_W'(opb) : ADDR_W'(opa));

    // Shift-add multiply: acc holds {partial high half, remaining multiplier bits}.
    assign mul_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, mc_b_q} : '0);
    assign mul_acc = {mul_sum, acc_q[DATA_W-1:1]};

`ifdef EXEC_DIV_EN
    localparam logic [3:0] OP_DIV = 4'd9;

    logic              mc_div_q, mc_div_d;
    logic [DATA_W:0]   rem_sh;
    logic              div_ge;
    logic [DATA_W-1:0] rem_nx;
    logic [2*DATA_W-1:0] div_acc;

    // Restoring divide: acc holds {remainder, dividend/quotient}; divisor 0 yields all-ones naturally.
    assign rem_sh  = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    assign div_ge  = rem_sh >= {1'b0, mc_b_q};
    assign rem_nx  = div_ge ? DATA_W'(rem_sh - {1'b0, mc_b_q}) : rem_sh[DATA_W-1:0];
    assign div_acc = {rem_nx, acc_q[DATA_W-2:0], div_ge};

    assign is_mc    = !sp_en && ((alu_op == OP_MUL) || (alu_op == OP_DIV));
    assign acc_step = mc_div_q ? div_acc : mul_acc;
    assign mc_cf    = mc_div_q ? (mc_b_q == '0) : (|acc_q[2*DATA_W-1:DATA_W]);

    assign mc_div_d = (state_q == S_IDLE && fire && is_mc) ? (alu_op == OP_DIV) : mc_div_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mc_div_q <= 1'b0;
        else        mc_div_q <= mc_div_d;
    end
`else
    assign is_mc    = !sp_en && (alu_op == OP_MUL);
    assign acc_step = mul_acc;
    assign mc_cf    = |acc_q[2*DATA_W-1:DATA_W];
`endif

    // fd: 00 clear CF, 01 set CF, 10 keep all, 11 NF/ZF from result and CF from the op where it defines one.
    function automatic logic [2:0] next_flags(input logic [2:0] cur, input logic [1:0] f,
                                              input logic [DATA_W-1:0] res, input logic cf,
                                              input logic cf_vld);
        logic [2:0] nf;
        nf = cur;
        case (f)
            2'b00: nf[1] = 1'b0;
            2'b01: nf[1] = 1'b1;
            2'b11: begin
                nf[2] = res[DATA_W-1];
                nf[0] = (res == '0);
                if (cf_vld) nf[1] = cf;
            end
            default: nf = cur;
        endcase
        return nf;
    endfunction

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_ctrl_d  = out_ctrl_q;
        flags_d     = flags_q;
        sp_d        = sp_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mc_b_d      = mc_b_q;
        mc_fd_d     = mc_fd_q;
        mc_addr_d   = mc_addr_q;
        mc_ctrl_d   = mc_ctrl_q;
        case (state_q)
            S_IDLE: begin
                if (fire) begin
                    if (is_mc) begin
                        state_d   = S_ITER;
                        cnt_d     = CNT_W'(DATA_W);
                        acc_d     = {{DATA_W{1'b0}}, opa};
                        mc_b_d    = opb;
                        mc_fd_d   = fd;
                        mc_addr_d = sc_addr;
                        mc_ctrl_d = ctrl_in;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = sc_res;
                        out_addr_d  = sc_addr;
                        out_ctrl_d  = ctrl_in;
                        flags_d     = next_flags(flags_q, fd, sc_res, alu_cf, !sp_en && alu_cf_vld);
                        if (sp_en) sp_d = sp_pop ? sp_inc : sp_dec;
                    end
                end
            end
            S_ITER: begin
                acc_d = acc_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                if (slot_free) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b1;
                    out_data_d  = acc_q[DATA_W-1:0];
                    out_addr_d  = mc_addr_q;
                    out_ctrl_d  = mc_ctrl_q;
                    flags_d     = next_flags(flags_q, mc_fd_q, acc_q[DATA_W-1:0], mc_cf, 1'b1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flags_load) flags_d = flags_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_ctrl_q  <= '0;
            flags_q     <= 3'b000;
            sp_q        <= SP_RESET;
            cnt_q       <= '0;
            acc_q       <= '0;
            mc_b_q      <= '0;
            mc_fd_q     <= 2'b00;
            mc_addr_q   <= '0;
            mc_ctrl_q   <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_ctrl_q  <= out_ctrl_d;
            flags_q     <= flags_d;
            sp_q        <= sp_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mc_b_q      <= mc_b_d;
            mc_fd_q     <= mc_fd_d;
            mc_addr_q   <= mc_addr_d;
            mc_ctrl_q   <= mc_ctrl_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_ctrl  = out_ctrl_q;
    assign flags     = flags_q;
    assign sp        = sp_q;
    assign busy      = (state_q != S_IDLE);

endmodule
